// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the execute-stage multiply/divide unit.
//   MDU_WIDTH   : default operand width (HI and LO are each this wide)
//   mdu_state_t : multiply/divide sequencer states
//   MULT..MFLO  : SPECIAL-opcode funct codes that the main decoder maps onto
//                 startE/divE/unsgnE/mfhiE/mfloE
package mips_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;

endpackage

// File: rtl/mdu_datapath.sv
// mdu_datapath: iterative magnitude datapath for muldiv_unit.
// Holds a 2*WIDTH accumulator split into accHi:accLo plus an operand register.
//   Multiply: accHi:accLo starts as 0:|b|, operand = |a|; each step adds the
//             operand into accHi when accLo[0] is set, then shifts right 1.
//   Divide:   accHi:accLo starts as 0:|a| (remainder:quotient), operand = |b|;
//             each step shifts left 1 and keeps a trial subtraction if it
//             does not go negative, setting the quotient LSB.
// After WIDTH steps accHi:accLo is the unsigned product, or remainder:quotient.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (clears all state)
//   load            : capture magA/magB and divMode, clear accHi
//   step            : perform one iteration in the mode captured at load
//   divMode         : 0 = multiply, 1 = divide (sampled with load)
//   magA, magB      : operand magnitudes (unsigned WIDTH-bit values)
//   accHi, accLo    : accumulator halves
module mdu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             divMode,
  input  logic [WIDTH-1:0] magA,
  input  logic [WIDTH-1:0] magB,
  output logic [WIDTH-1:0] accHi,
  output logic [WIDTH-1:0] accLo
);

  logic [WIDTH-1:0] opReg;
  logic             divReg;

  // Multiply adder: one carry bit beyond WIDTH, shifted back in on the right shift.
  logic [WIDTH:0]   mulSum;
  // Divide: remainder shifted left with the quotient MSB; the remainder is
  // always below the divisor, so WIDTH+1 bits hold it and one more bit is the sign.
  logic [WIDTH:0]   shiftRem;
  logic [WIDTH+1:0] trialDiff;

  always_comb begin
    mulSum    = {1'b0, accHi} + (accLo[0] ? {1'b0, opReg} : '0);
    shiftRem  = {accHi, accLo[WIDTH-1]};
    trialDiff = {1'b0, shiftRem} - {2'b00, opReg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      accHi  <= '0;
      accLo  <= '0;
      opReg  <= '0;
      divReg <= 1'b0;
    end else if (load) begin
      divReg <= divMode;
      accHi  <= '0;
      accLo  <= divMode ? magA : magB;
      opReg  <= divMode ? magB : magA;
    end else if (step) begin
      if (divReg) begin
        if (!trialDiff[WIDTH+1]) begin
          accHi <= trialDiff[WIDTH-1:0];
          accLo <= {accLo[WIDTH-2:0], 1'b1};
        end else begin
          accHi <= shiftRem[WIDTH-1:0];
          accLo <= {accLo[WIDTH-2:0], 1'b0};
        end
      end else begin
        accHi <= mulSum[WIDTH:1];
        accLo <= {mulSum[0], accLo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: execute-stage multiply/divide unit with HI/LO registers.
// Sequencer IDLE -> RUN (WIDTH iterations) -> FIX (sign correction, HI/LO write).
// Signed operands are reduced to magnitudes at start; FIX restores the signs.
// Optional build macro MDU_UNSIGNED_EN: when defined, unsgnE=1 runs MULTU/DIVU
// (no magnitude reduction, no sign correction). When undefined, unsgnE is
// ignored and every operation is signed.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   startE, divE    : launch MULT/DIV; divE selects divide
//   unsgnE          : unsigned op (only with MDU_UNSIGNED_EN)
//   srcaE, srcbE    : rs (multiplicand/dividend), rt (multiplier/divisor)
//   mfhiE, mfloE    : MFHI / MFLO in E stage
//   mfresultE       : HI when mfhiE, else LO
//   busyE           : registered, high while an operation is in flight
//   stallE          : MFHI/MFLO must wait for an in-flight or launching op
//   hi, lo          : architectural HI/LO
//   dbgState        : current sequencer state
//
// Handshake: a start is accepted only when busyE=0; a start while busyE=1 is
// dropped. busyE falls in the cycle HI/LO first show the new result, so a
// stalled MFHI/MFLO reads the right value in the cycle stallE drops.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic             divE,
  input  logic             unsgnE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             mfhiE,
  input  logic             mfloE,
  output logic [WIDTH-1:0] mfresultE,
  output logic             busyE,
  output logic             stallE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mdu_state_t       dbgState
);

  mdu_state_t       state;
  logic [CNTW-1:0]  counter;
  logic             divOp;
  logic             negRes;   // product / quotient sign
  logic             negRem;   // remainder follows the dividend
  logic             divZero;
  logic [WIDTH-1:0] rawA;     // raw dividend, HI result for divide by zero

  logic             signedOp;
  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic             dpLoad;
  logic             dpStep;
  logic             dpDiv;
  logic [WIDTH-1:0] accHi;
  logic [WIDTH-1:0] accLo;

  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

`ifdef MDU_UNSIGNED_EN
  assign signedOp = ~unsgnE;
`else
  logic unusedUnsgn;
  assign signedOp    = 1'b1;
  assign unusedUnsgn = unsgnE;
`endif

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    aNeg = signedOp & srcaE[WIDTH-1];
    bNeg = signedOp & srcbE[WIDTH-1];
    magA = aNeg ? -srcaE : srcaE;
    magB = bNeg ? -srcbE : srcbE;
  end

  assign dpLoad = (state == IDLE) && startE;
  assign dpStep = (state == RUN);
  assign dpDiv  = dpLoad ? divE : divOp;

  mdu_datapath #(.WIDTH(WIDTH)) uDatapath (
    .clk     (clk),
    .reset   (reset),
    .load    (dpLoad),
    .step    (dpStep),
    .divMode (dpDiv),
    .magA    (magA),
    .magB    (magB),
    .accHi   (accHi),
    .accLo   (accLo)
  );

  always_comb begin
    prodFix = negRes ? -{accHi, accLo} : {accHi, accLo};
    quoFix  = negRes ? -accLo : accLo;
    remFix  = negRem ? -accHi : accHi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      busyE   <= 1'b0;
      divOp   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      rawA    <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startE) begin
            state   <= RUN;
            counter <= CNTW'(WIDTH);
            busyE   <= 1'b1;
            divOp   <= divE;
            negRes  <= aNeg ^ bNeg;
            negRem  <= aNeg;
            divZero <= (srcbE == '0);
            rawA    <= srcaE;
          end
        end
        RUN: begin
          counter <= counter - CNTW'(1);
          if (counter == CNTW'(1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busyE <= 1'b0;
          if (!divOp) begin
            hi <= prodFix[2*WIDTH-1:WIDTH];
            lo <= prodFix[WIDTH-1:0];
          end else if (divZero) begin
            hi <= rawA;
            lo <= '1;
          end else begin
            hi <= remFix;
            lo <= quoFix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mfresultE = mfhiE ? hi : lo;
  assign stallE    = (mfhiE | mfloE) & (busyE | startE);
  assign dbgState  = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + randomized bench for muldiv_unit (WIDTH=32).
// Expected HI/LO come from plain 64-bit integer arithmetic on the operands.
module tb_muldiv_unit;
  import mips_pkg::*;

  localparam int W = 32;
  localparam int BUSY_CYCLES = W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         startE = 1'b0;
  logic         divE = 1'b0;
  logic         unsgnE = 1'b0;
  logic [W-1:0] srcaE = '0;
  logic [W-1:0] srcbE = '0;
  logic         mfhiE = 1'b0;
  logic         mfloE = 1'b0;
  logic [W-1:0] mfresultE;
  logic         busyE;
  logic         stallE;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  mdu_state_t   dbgState;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .startE    (startE),
    .divE      (divE),
    .unsgnE    (unsgnE),
    .srcaE     (srcaE),
    .srcbE     (srcbE),
    .mfhiE     (mfhiE),
    .mfloE     (mfloE),
    .mfresultE (mfresultE),
    .busyE     (busyE),
    .stallE    (stallE),
    .hi        (hi),
    .lo        (lo),
    .dbgState  (dbgState)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {hi, lo} from integer arithmetic.
  function automatic logic [2*W-1:0] ref_op(input bit div, input bit sgn,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [2*W-1:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!div) begin
      if (sgn) res = 64'(sa * sb);
      else     res = {32'b0, a} * {32'b0, b};
    end else if (b == '0) begin
      res = {a, 32'hFFFF_FFFF};
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  function automatic bit eff_signed(input bit unsgn);
`ifdef MDU_UNSIGNED_EN
    return !unsgn;
`else
    return (unsgn == unsgn);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Present a start at the negedge, hold across one posedge, then release.
  task automatic drive_start(input bit div, input bit unsgn,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    startE = 1'b1;
    divE   = div;
    unsgnE = unsgn;
    srcaE  = a;
    srcbE  = b;
    @(posedge clk);
    #1 startE = 1'b0;
  endtask

  // Full operation: checks busy length, HI/LO hold during the run, final HI/LO.
  // inject drives a spurious start mid-run, which must have no effect.
  task automatic run_op(input string tag, input bit div, input bit unsgn,
                        input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    logic [2*W-1:0] exp;
    logic [W-1:0]   old_hi, old_lo;
    int             busy;
    exp_q.push_back(ref_op(div, eff_signed(unsgn), a, b));
    old_hi = hi;
    old_lo = lo;
    drive_start(div, unsgn, a, b);
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      startE = 1'b0;
      if (!busyE) break;
      busy++;
      if (inject && busy == 5) begin
        startE = 1'b1;
        divE   = ~div;
        srcaE  = $urandom;
        srcbE  = $urandom;
      end
      if (busy == 10) begin
        check({tag, "_hold_hi"}, hi, old_hi);
        check({tag, "_hold_lo"}, lo, old_lo);
      end
    end
    exp = exp_q.pop_front();
    check({tag, "_busy_cycles"}, W'(busy), W'(BUSY_CYCLES));
    check({tag, "_hi"}, hi, exp[2*W-1:W]);
    check({tag, "_lo"}, lo, exp[W-1:0]);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [2*W-1:0] exp;
    bit             stall_ok;
    int             busy;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);
    check("reset_busy", W'(busyE), '0);
    check("reset_state", W'(dbgState), W'(IDLE));

    run_op("mult_7x-3", 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op("div_-17/5", 1'b1, 1'b0, 32'hFFFF_FFEF, 32'd5, 1'b0);
    run_op("div_ovf", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("div_by_zero", 1'b1, 1'b0, 32'd42, 32'd0, 1'b0);
    run_op("mult_minmin", 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("div_-7/-2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
    run_op("multu_ff_x2", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op("ignored_start", 1'b0, 1'b0, 32'h0000_1234, 32'h0000_0055, 1'b1);

    // MFLO in the start cycle and the following ones must stall until busy falls.
    exp_q.push_back(ref_op(1'b1, 1'b1, 32'd1000, 32'd7));
    @(negedge clk);
    startE = 1'b1;
    divE   = 1'b1;
    unsgnE = 1'b0;
    srcaE  = 32'd1000;
    srcbE  = 32'd7;
    mfloE  = 1'b1;
    #1 check("stall_start_cycle", W'(stallE), W'(1));
    @(posedge clk);
    #1 startE = 1'b0;
    stall_ok = 1'b1;
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busyE) break;
      busy++;
      if (!stallE) stall_ok = 1'b0;
    end
    exp = exp_q.pop_front();
    check("stall_while_busy", W'(stall_ok), W'(1));
    check("stall_busy_cycles", W'(busy), W'(BUSY_CYCLES));
    check("stall_released", W'(stallE), W'(0));
    check("mflo_result", mfresultE, exp[W-1:0]);
    mfloE = 1'b0;
    mfhiE = 1'b1;
    #1 check("mfhi_result", mfresultE, exp[2*W-1:W]);
    mfhiE = 1'b0;

    // Reset mid-multiply: HI/LO must clear, not take a partial result.
    drive_start(1'b0, 1'b0, 32'h1234_5678, 32'h9);
    repeat (10) @(negedge clk);
    check("pre_reset_busy", W'(busyE), W'(1));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", W'(busyE), '0);
    check("abort_hi", hi, '0);
    check("abort_lo", lo, '0);
    check("abort_state", W'(dbgState), W'(IDLE));
    repeat (3) @(negedge clk);
    check("abort_stays_idle", W'(busyE), '0);

    run_op("after_abort", 1'b0, 1'b0, 32'h1234_5678, 32'h9, 1'b0);

    // Randomized operations, some back-to-back.
    for (int n = 0; n < 24; n++) begin
      run_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             pick_operand(), pick_operand(), 1'($urandom_range(0, 3) == 0));
    end

    check("queue_empty", W'(exp_q.size()), '0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage multiply/divide unit that services the MULT, DIV, MFHI and MFLO control decodes issued by the main decoder.
- Runs an iterative signed shift-add multiply or restoring divide over WIDTH cycles.
- Holds results in architectural HI/LO registers.
- Drives a stall request to the hazard unit while an MFHI/MFLO depends on an operation still in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNTW, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- startE  in  1  launch MULT/DIV this cycle (decoded in D, registered into E)
- divE  in  1  0 = multiply, 1 = divide; valid with startE
- unsgnE  in  1  unsigned op (MULTU/DIVU); used only with MDU_UNSIGNED_EN
- srcaE  in  WIDTH  rs operand (multiplicand / dividend)
- srcbE  in  WIDTH  rt operand (multiplier / divisor)
- mfhiE  in  1  MFHI in E stage
- mfloE  in  1  MFLO in E stage
- mfresultE  out  WIDTH  HI when mfhiE, else LO
- busyE  out  1  operation in flight (registered)
- stallE  out  1  combinational: (mfhiE|mfloE) & (busyE|startE)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (synchronous): state=IDLE, hi=0, lo=0, busyE=0, counter=0, internal accumulators=0. Reset asserted mid-operation aborts it; HI/LO become 0, not a partial result.
- FSM states:
  - IDLE: startE=1 latches |srcaE|, |srcbE| (signed mode), result-sign flags and divE; counter=WIDTH; go to RUN. No start: stay.
  - RUN: one iteration per cycle, counter decrements; counter reaches 1 -> FIX.
    - Multiply: add multiplicand to upper half of a 2*WIDTH accumulator if LSB set, then shift right 1.
    - Divide: shift remainder:quotient left 1; trial subtract divisor; keep it and set quotient LSB if non-negative.
  - FIX: apply sign correction, write hi/lo, return to IDLE.
    - Multiply: negate the 2*WIDTH product if sign(a)^sign(b).
    - Divide: negate quotient if sign(a)^sign(b); remainder takes sign of dividend.
- Latency: start sampled at cycle 0; busyE high cycles 1..WIDTH+1; hi/lo valid from cycle WIDTH+2; busyE low in that same cycle. Back-to-back start legal at cycle WIDTH+2.
- startE while busyE=1 is ignored (hazard unit must not issue it); in-flight op unaffected.
- hi/lo unchanged during RUN; old values remain readable by bypass-free logic until FIX writes.
- mfresultE is combinational from hi/lo; stallE holds pipeline until busyE falls, then correct value is read the following cycle.
- Multiply: hi = product[2W-1:W], lo = product[W-1:0].
- Divide: lo = quotient, hi = remainder.
- Divide by zero (decided): lo = all ones, hi = dividend (raw srcaE), no trap.
- Signed overflow 0x80000000 / -1: lo = 0x80000000, hi = 0.
- Operand magnitude of 0x80000000 handled as unsigned WIDTH-bit value (no extra bit needed).

Optional Feature:
- Macro MDU_UNSIGNED_EN.
- Defined: unsgnE=1 skips absolute-value and FIX sign correction (MULTU/DIVU semantics), same latency.
- Undefined: unsgnE ignored; all operations signed.

Decomposition:
- Shared package mips_pkg: WIDTH default constant; mdu_state_t enum {IDLE, RUN, FIX}; funct constants MULT, MULTU, DIV, DIVU, MFHI, MFLO.
- One natural sub-module: mdu_datapath (accumulator/remainder registers, adder/subtractor, shifts) under control of the FSM in muldiv_unit.

Test Plan:
- MULT 7 x -3 -> busyE high 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -17 / 5 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2) at cycle 34.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIV 42 / 0 -> lo=0xFFFFFFFF, hi=42.
- MFLO asserted the cycle after startE -> stallE=1 until busyE falls; then mfresultE equals new lo.
- Reset asserted at iteration 10 of MULT 0x12345678 x 0x9 -> next cycle IDLE, busyE=0, hi=lo=0.
- With MDU_UNSIGNED_EN, MULTU 0xFFFFFFFF x 2 -> hi=1, lo=0xFFFFFFFE. Without the macro the same inputs give hi=0xFFFFFFFF, lo=0xFFFFFFFE.
